// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: blocking miss/write-through controller between a CPU-side cache and backing memory
module cache_miss_ctrl #(
    parameter int ADDRESS_WIDTH = 17,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      MemRead,
    input  logic [DATA_WIDTH/8-1:0]   WE,
    input  logic [ADDRESS_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]     WD,
    input  logic                      hit,
    output logic [DATA_WIDTH-1:0]     FoundData,
    output logic                      FillValid,
    output logic                      Stall,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [15:0]               miss_count
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, FILL, WR_WAIT, WR_DONE} state_t;
    state_t state;
    logic st_req, rd_miss;
    assign st_req  = |WE;
    assign rd_miss = MemRead & ~hit;
    // Stall must reach the CPU in the same cycle a request is accepted, so it is decoded combinationally
    assign Stall = (state == RD_WAIT) || (state == WR_WAIT) || (state == IDLE && (st_req || rd_miss));
    // Controller state, memory request registers, refill capture and miss counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            FoundData  <= '0;
            FillValid  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            miss_count <= '0;
        end else begin
            FillValid <= 1'b0;
            case (state)
                IDLE: if (st_req || rd_miss) begin
                    mem_addr  <= A & ~ADDRESS_WIDTH'(3);
                    mem_be    <= WE;
                    mem_wdata <= WD;
                    mem_req   <= 1'b1;
                    mem_we    <= st_req;
                    state     <= st_req ? WR_WAIT : RD_WAIT;
                    if (!st_req && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                end
                RD_WAIT: if (mem_ack) begin
                    FoundData <= mem_rdata;
                    FillValid <= 1'b1;
                    mem_req   <= 1'b0;
                    state     <= FILL;
                end
                WR_WAIT: if (mem_ack) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    state   <= WR_DONE;
                end
                FILL:    state <= IDLE;
                WR_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: transaction-level model plus directed scenarios for cache_miss_ctrl
module tb_cache_miss_ctrl;
    localparam int AW = 17;
    localparam int DW = 32;
    logic CLK = 0, RST = 1, MemRead = 0, hit = 0, mem_ack = 0;
    logic [3:0] WE = 0;
    logic [AW-1:0] A = 0;
    logic [DW-1:0] WD = 0, mem_rdata = 0;
    logic [DW-1:0] FoundData, mem_wdata;
    logic FillValid, Stall, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0] mem_be;
    logic [15:0] miss_count;
    int checks = 0, failures = 0;

    cache_miss_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .WE(WE), .A(A), .WD(WD), .hit(hit),
        .FoundData(FoundData), .FillValid(FillValid), .Stall(Stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
        end
    endtask

    // model: outstanding transaction kind (0 none, 1 read, 2 write), one-cycle post phase (0 none, 1 fill, 2 write done)
    int m_busy = 0, m_post = 0, m_misses = 0;
    bit m_live = 0;
    logic [AW-1:0] m_addr = 0;
    logic [3:0] m_be = 0;
    logic [DW-1:0] m_wdata = 0, m_found = 0;

    always @(posedge CLK) begin
        if (RST) begin
            m_busy = 0; m_post = 0; m_misses = 0; m_addr = 0; m_be = 0; m_wdata = 0; m_found = 0; m_live = 1;
        end else if (m_post != 0) begin
            m_post = 0;
        end else if (m_busy == 0) begin
            if (|WE || (MemRead && !hit)) begin
                m_busy = (|WE) ? 2 : 1;
                m_addr = {A[AW-1:2], 2'b00};
                m_be = WE;
                m_wdata = WD;
                if (m_busy == 1) m_misses++;
            end
        end else if (mem_ack) begin
            if (m_busy == 1) begin
                m_found = mem_rdata;
                m_post = 1;
            end else m_post = 2;
            m_busy = 0;
        end
    end

    always @(negedge CLK) begin
        if (m_live) begin
            check("m_stall", 64'(Stall), 64'(m_busy != 0 || (m_post == 0 && (|WE || (MemRead && !hit)))));
            check("m_req", 64'(mem_req), 64'(m_busy != 0));
            check("m_we", 64'(mem_we), 64'(m_busy == 2));
            check("m_fill", 64'(FillValid), 64'(m_post == 1));
            check("m_found", 64'(FoundData), 64'(m_found));
            check("m_addr", 64'(mem_addr), 64'(m_addr));
            check("m_be", 64'(mem_be), 64'(m_be));
            check("m_wdata", 64'(mem_wdata), 64'(m_wdata));
            check("m_count", 64'(miss_count), 64'(m_misses > 65535 ? 65535 : m_misses));
        end
    end

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    int stalls, reqs;
    bit fill_seen;

    initial begin
        nxt(); nxt();
        RST = 0;
        mid();
        check("rst_req", 64'(mem_req), 0);
        check("rst_stall", 64'(Stall), 0);
        check("rst_count", 64'(miss_count), 0);
        check("rst_found", 64'(FoundData), 0);
        nxt();
        MemRead = 1; hit = 0; A = 17'h00104;
        mid();
        check("rd_stall0", 64'(Stall), 1);
        stalls = 1; reqs = 0;
        nxt();
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
            mid();
            check("rd_addr", 64'(mem_addr), 64'h00104);
            stalls += int'(Stall);
            reqs += int'(mem_req);
            nxt();
        end
        mem_ack = 0; MemRead = 0; WE = 4'hF; WD = 32'h12345678; A = 17'h00011;
        mid();
        check("fill_valid", 64'(FillValid), 1);
        check("fill_data", 64'(FoundData), 64'hDEADBEEF);
        check("fill_stall", 64'(Stall), 0);
        check("fill_req", 64'(mem_req), 0);
        check("rd_stall_cycles", 64'(stalls), 4);
        check("rd_req_cycles", 64'(reqs), 3);
        nxt();
        mid();
        check("held_store_stall", 64'(Stall), 1);
        check("rd_count", 64'(miss_count), 1);
        nxt();
        mem_ack = 1;
        mid();
        check("held_store_we", 64'(mem_we), 1);
        check("held_store_addr", 64'(mem_addr), 64'h00010);
        nxt();
        mem_ack = 0; WE = 0;
        mid();
        check("wrdone_stall", 64'(Stall), 0);
        nxt();
        MemRead = 1; hit = 1; mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
        mid();
        check("hit_stall", 64'(Stall), 0);
        check("hit_req", 64'(mem_req), 0);
        nxt();
        mid();
        check("idle_ack_ignored", 64'(FoundData), 64'hDEADBEEF);
        check("hit_count", 64'(miss_count), 1);
        nxt();
        MemRead = 0; mem_ack = 0;
        WE = 4'b0010; A = 17'h00203; WD = 32'h0000AB00; hit = 1;
        mid();
        check("st_stall0", 64'(Stall), 1);
        nxt();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ack = 1;
            mid();
            check("st_addr", 64'(mem_addr), 64'h00200);
            check("st_be", 64'(mem_be), 64'b0010);
            check("st_we", 64'(mem_we), 1);
            check("st_stall", 64'(Stall), 1);
            nxt();
        end
        mem_ack = 0; WE = 0;
        mid();
        check("st_done_stall", 64'(Stall), 0);
        check("st_done_req", 64'(mem_req), 0);
        nxt();
        MemRead = 1; WE = 4'hF; hit = 0; A = 17'h00300; WD = 32'hA5A5A5A5;
        mid();
        check("both_stall", 64'(Stall), 1);
        nxt();
        mem_ack = 1;
        mid();
        check("both_we", 64'(mem_we), 1);
        check("both_count", 64'(miss_count), 1);
        nxt();
        mem_ack = 0; WE = 0; MemRead = 0;
        nxt();
        MemRead = 1; hit = 0; A = 17'h00404;
        nxt();
        MemRead = 0; RST = 1;
        mid();
        check("rstrd_req_before", 64'(mem_req), 1);
        nxt();
        RST = 0;
        mid();
        check("rstrd_req", 64'(mem_req), 0);
        check("rstrd_found", 64'(FoundData), 0);
        check("rstrd_count", 64'(miss_count), 0);
        nxt();
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        fill_seen = 0;
        for (int i = 0; i < 3; i++) begin
            mid();
            fill_seen |= FillValid;
            nxt();
            mem_ack = 0;
        end
        check("rstrd_no_fill", 64'(fill_seen), 0);
        check("rstrd_found_after", 64'(FoundData), 0);
        force dut.miss_count = 16'hFFFE;
        m_misses = 65534;
        #1 release dut.miss_count;
        for (int i = 0; i < 3; i++) begin
            MemRead = 1; hit = 0; A = AW'(17'h01000 + 4 * i);
            nxt();
            MemRead = 0; mem_ack = 1; mem_rdata = DW'(i);
            nxt();
            mem_ack = 0;
            nxt();
            mid();
            check("sat_count", 64'(miss_count), 64'hFFFF);
            nxt();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
